thunderbird_seq_ctrl: RTL and testbench

Sequencer and request arbiter for the Thunderbird tail-light lamp datapath: 3 left lamps (LL) and 3 right lamps (RL), driven from the hazard/left/right switches on the DE2-115 board.
- Synchronises the switch requests and arbitrates them by priority.
- Generates its own lamp-step tick from CLOCK_50.
- Steps a Moore state machine one state per tick.
- Sits between the SW inputs and the LEDG lamp outputs, and replaces the free-running divided-clock scheme with a single-clock, tick-enabled design.

---
 rtl/thunderbird_pkg.sv | 44 ++++
 rtl/nhz_tick.sv | 32 +++
 rtl/thunderbird_seq_ctrl.sv | 94 +++++++++
 tb/tb_thunderbird_seq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/thunderbird_pkg.sv
// Shared types and constants for the Thunderbird tail-light sequencer.
//   state_t      : sequencer states (3-bit encoding)
//   LAMP_*       : lamp bar patterns, bit 0 is the innermost lamp
//   SW_*         : bit positions of the hazard/left/right requests in SW
//   lamp_decode  : Moore decode of a state into {LL, RL}
package thunderbird_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HAZ  = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  localparam int SW_H = 2;
  localparam int SW_L = 1;
  localparam int SW_R = 0;

  // Returns {LL, RL} for a given state.
  function automatic logic [5:0] lamp_decode(input state_t st);
    logic [5:0] lamps;
    case (st)
      ST_L1:   lamps = {LAMP_1,   LAMP_OFF};
      ST_L2:   lamps = {LAMP_2,   LAMP_OFF};
      ST_L3:   lamps = {LAMP_3,   LAMP_OFF};
      ST_R1:   lamps = {LAMP_OFF, LAMP_1};
      ST_R2:   lamps = {LAMP_OFF, LAMP_2};
      ST_R3:   lamps = {LAMP_OFF, LAMP_3};
      ST_HAZ:  lamps = {LAMP_3,   LAMP_3};
      default: lamps = {LAMP_OFF, LAMP_OFF};
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/nhz_tick.sv
// Prescaler producing a one-cycle enable strobe every TICK_DIV clocks.
// The count runs 0..TICK_DIV-1 and tick is high while count is at its
// last value, so the first strobe after reset lands in cycle TICK_DIV-1.
//   CLOCK_50 : system clock
//   reset    : synchronous, active-high
//   tick     : one-cycle strobe
module nhz_tick #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/thunderbird_seq_ctrl.sv
// Thunderbird tail-light sequencer: synchronises the hazard/left/right
// switches, arbitrates them (H > L&R > L > R) and steps a Moore FSM once
// per prescaler tick. Lamps and busy are registered alongside the state.
//   CLOCK_50 : system clock (only clock)
//   reset    : synchronous, active-high
//   SW       : raw requests, SW[2]=hazard, SW[1]=left, SW[0]=right
//   LL, RL   : left/right lamp bars, bit 0 innermost
//   tick     : lamp-step strobe
//   busy     : state is not IDLE
//
// state | meaning
// IDLE  | all lamps off, waiting for a request
// L1    | left inner lamp on
// L2    | left inner two lamps on
// L3    | all left lamps on, returns to IDLE next
// R1    | right inner lamp on
// R2    | right inner two lamps on
// R3    | all right lamps on, returns to IDLE next
// HAZ   | all six lamps on, returns to IDLE next
module thunderbird_seq_ctrl
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV    = 12_500_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] SW,
  output logic [2:0] LL,
  output logic [2:0] RL,
  output logic       tick,
  output logic       busy
);

  logic [2:0] sync_q [SYNC_STAGES];
  logic       h_s, l_s, r_s;
  state_t     state, state_nxt;

  nhz_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= SW;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign h_s = sync_q[SYNC_STAGES-1][SW_H];
  assign l_s = sync_q[SYNC_STAGES-1][SW_L];
  assign r_s = sync_q[SYNC_STAGES-1][SW_R];

  // Left and right sequences only ever return through IDLE, so a change of
  // direction always costs one idle tick. L3/R3 finish even under hazard.
  function automatic state_t next_state(input state_t st, input logic h,
                                        input logic l, input logic r);
    state_t ns;
    case (st)
      ST_IDLE: begin
        if (h || (l && r)) ns = ST_HAZ;
        else if (l)        ns = ST_L1;
        else if (r)        ns = ST_R1;
        else               ns = ST_IDLE;
      end
      ST_L1:   ns = h ? ST_HAZ : ST_L2;
      ST_L2:   ns = h ? ST_HAZ : ST_L3;
      ST_R1:   ns = h ? ST_HAZ : ST_R2;
      ST_R2:   ns = h ? ST_HAZ : ST_R3;
      default: ns = ST_IDLE;
    endcase
    return ns;
  endfunction

  assign state_nxt = next_state(state, h_s, l_s, r_s);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_IDLE;
      LL    <= LAMP_OFF;
      RL    <= LAMP_OFF;
      busy  <= 1'b0;
    end else if (tick) begin
      state    <= state_nxt;
      {LL, RL} <= lamp_decode(state_nxt);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_thunderbird_seq_ctrl.sv
module tb_thunderbird_seq_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int SYNC_STAGES = 2;

  logic       CLOCK_50;
  logic       reset;
  logic [2:0] SW;
  logic [2:0] LL, RL;
  logic       tick, busy;

  thunderbird_seq_ctrl #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .SW       (SW),
    .LL       (LL),
    .RL       (RL),
    .tick     (tick),
    .busy     (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_pass = 0;
  int n_chk  = 0;

  // Hand-computed expectation posted by the stimulus, consumed by the checker
  int         lit_req = 0;
  string      lit_name;
  logic [2:0] lit_ll, lit_rl;
  logic       lit_tick, lit_busy;

  int cyc;
  logic done = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  function automatic logic [2:0] bar(input int lit_count);
    return 3'((1 << lit_count) - 1);
  endfunction

  // Checker + behavioural model. Model holds: cycles since release (mod
  // TICK_DIV), a mode (0 idle, 1 left, 2 right, 3 hazard), a step count
  // within the left/right sweep, and a history of raw switch values.
  initial begin
    int         m_cnt, m_mode, m_step, lit_seen;
    logic [2:0] hist [$];
    logic [2:0] s, e_ll, e_rl;
    logic       e_tick, e_busy;
    m_cnt = 0; m_mode = 0; m_step = 0; lit_seen = 0;
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(3'b000);
    forever begin
      @(negedge CLOCK_50);
      e_ll   = (m_mode == 1) ? bar(m_step) : (m_mode == 3) ? 3'b111 : 3'b000;
      e_rl   = (m_mode == 2) ? bar(m_step) : (m_mode == 3) ? 3'b111 : 3'b000;
      e_tick = (m_cnt == TICK_DIV - 1);
      e_busy = (m_mode != 0);
      chk("mdl_LL",   int'(LL),   int'(e_ll));
      chk("mdl_RL",   int'(RL),   int'(e_rl));
      chk("mdl_tick", int'(tick), int'(e_tick));
      chk("mdl_busy", int'(busy), int'(e_busy));
      if (lit_req != lit_seen) begin
        lit_seen = lit_req;
        chk({lit_name, "_LL"},   int'(LL),   int'(lit_ll));
        chk({lit_name, "_RL"},   int'(RL),   int'(lit_rl));
        chk({lit_name, "_tick"}, int'(tick), int'(lit_tick));
        chk({lit_name, "_busy"}, int'(busy), int'(lit_busy));
      end
      // advance model across the coming edge
      if (reset) begin
        m_cnt = 0; m_mode = 0; m_step = 0;
        for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 3'b000;
      end else begin
        s = hist[0];
        if (e_tick) begin
          if (m_mode == 0) begin
            if (s[2] || (s[1] && s[0])) m_mode = 3;
            else if (s[1]) begin m_mode = 1; m_step = 1; end
            else if (s[0]) begin m_mode = 2; m_step = 1; end
          end else if (m_mode == 3) begin
            m_mode = 0;
          end else if (s[2] && m_step < 3) begin
            m_mode = 3;
          end else if (m_step == 3) begin
            m_mode = 0;
          end else begin
            m_step++;
          end
        end
        m_cnt = (m_cnt + 1) % TICK_DIV;
        void'(hist.pop_front());
        hist.push_back(SW);
      end
      if (done) begin
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
    end
  endtask

  task automatic expect_at(input int k, input string name, input logic [2:0] ll,
                           input logic [2:0] rl, input logic t, input logic b);
    goto(k);
    lit_name = name; lit_ll = ll; lit_rl = rl; lit_tick = t; lit_busy = b;
    lit_req++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b1;
    SW    = 3'b000;
    cyc   = 0;

    // idle: tick cadence
    do_reset(3);
    expect_at(2,  "s1_c2",  3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(3,  "s1_c3",  3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(7,  "s1_c7",  3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(11, "s1_c11", 3'b000, 3'b000, 1'b1, 1'b0);
    goto(12);

    // left sweep held
    SW = 3'b010;
    do_reset(2);
    expect_at(3,  "s2_c3",  3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(4,  "s2_c4",  3'b001, 3'b000, 1'b0, 1'b1);
    expect_at(8,  "s2_c8",  3'b011, 3'b000, 1'b0, 1'b1);
    expect_at(12, "s2_c12", 3'b111, 3'b000, 1'b0, 1'b1);
    expect_at(15, "s2_c15", 3'b111, 3'b000, 1'b1, 1'b1);
    expect_at(16, "s2_c16", 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(20, "s2_c20", 3'b001, 3'b000, 1'b0, 1'b1);
    goto(21);

    // right, hazard added during R1
    SW = 3'b001;
    do_reset(2);
    goto(4);
    SW = 3'b101;
    expect_at(4,  "s3_c4",  3'b000, 3'b001, 1'b0, 1'b1);
    expect_at(7,  "s3_c7",  3'b000, 3'b001, 1'b1, 1'b1);
    expect_at(8,  "s3_c8",  3'b111, 3'b111, 1'b0, 1'b1);
    expect_at(12, "s3_c12", 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(16, "s3_c16", 3'b111, 3'b111, 1'b0, 1'b1);
    expect_at(20, "s3_c20", 3'b000, 3'b000, 1'b0, 1'b0);
    goto(21);

    // left and right together behave as hazard
    SW = 3'b011;
    do_reset(2);
    expect_at(4,  "s4_c4",  3'b111, 3'b111, 1'b0, 1'b1);
    expect_at(8,  "s4_c8",  3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(12, "s4_c12", 3'b111, 3'b111, 1'b0, 1'b1);
    goto(13);

    // reset during L2
    SW = 3'b010;
    do_reset(2);
    expect_at(9, "s5_c9", 3'b011, 3'b000, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    cyc = 0;
    expect_at(0, "s5_r0", 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(3, "s5_r3", 3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(4, "s5_r4", 3'b001, 3'b000, 1'b0, 1'b1);
    goto(5);

    // short pulse between ticks ignored; left dropped during L1 completes
    SW = 3'b000;
    do_reset(2);
    goto(10);
    SW = 3'b010;
    goto(12);
    SW = 3'b000;
    expect_at(12, "s6_c12", 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(15, "s6_c15", 3'b000, 3'b000, 1'b1, 1'b0);
    expect_at(16, "s6_c16", 3'b000, 3'b000, 1'b0, 1'b0);
    goto(20);
    SW = 3'b010;
    goto(24);
    SW = 3'b000;
    expect_at(24, "s6_c24", 3'b001, 3'b000, 1'b0, 1'b1);
    expect_at(28, "s6_c28", 3'b011, 3'b000, 1'b0, 1'b1);
    expect_at(32, "s6_c32", 3'b111, 3'b000, 1'b0, 1'b1);
    expect_at(36, "s6_c36", 3'b000, 3'b000, 1'b0, 1'b0);
    expect_at(40, "s6_c40", 3'b000, 3'b000, 1'b0, 1'b0);
    goto(41);
    done = 1'b1;
  end

endmodule
